// File: rtl/ps2_key_tracker_if.sv
// rtl/ps2_key_tracker_if.sv - PS/2 pins, soft clear and key tracker result bundle
interface ps2_key_tracker_if #(
  parameter int NUM_VOICES = 2
);
  logic                    ps2_clk;
  logic                    ps2_dat;
  logic                    clear_n;
  logic [7:0]              scandata;
  logic                    scan_valid;
  logic                    frame_err;
  logic                    overflow;
  logic [NUM_VOICES-1:0]   key_on;
  logic [8*NUM_VOICES-1:0] key_codes;

  modport master (
    output ps2_clk, ps2_dat, clear_n,
    input  scandata, scan_valid, frame_err, overflow, key_on, key_codes
  );

  modport slave (
    input  ps2_clk, ps2_dat, clear_n,
    output scandata, scan_valid, frame_err, overflow, key_on, key_codes
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 receiver with make/break decoding and polyphonic key slots
module ps2_key_tracker #(
  parameter int NUM_VOICES  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             iCLK_50,
  input  logic             reset,
  ps2_key_tracker_if.slave bus
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_s, dat_s;
  logic                   filt_q, filt_d;
  logic [FLT_W-1:0]       filt_cnt_q, filt_cnt_d;
  logic                   sample_evt;

  rx_state_t              state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [7:0]             scandata_q, scandata_d;
  logic                   scan_valid_q, scan_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic [NUM_VOICES-1:0]   key_on_q, key_on_d;
  logic [8*NUM_VOICES-1:0] key_codes_q, key_codes_d;
  logic                    brk_q, brk_d;
  logic                    ext_q, ext_d;
  logic                    overflow_q, overflow_d;
  logic                    held, hit;

  function automatic logic is_musical(input logic [7:0] c);
    case (c)
      8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
      8'h33, 8'h3B, 8'h43, 8'h42, 8'h4B, 8'h4C, 8'h44, 8'h4D, 8'h52, 8'h5B:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples;
  // the cycle of a high-to-low flip is the sample event.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    sample_evt = 1'b0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FLT_LAST) begin
        filt_d     = clk_s;
        sample_evt = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_dat};
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    scandata_d   = scandata_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == IDLE || sample_evt) tmo_d = '0;
    else                               tmo_d = tmo_q + 1'b1;

    if (sample_evt) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d = {dat_s, shift_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = PARITY;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          if (dat_s && (^{shift_q, par_q})) begin
            scan_valid_d = 1'b1;
            scandata_d   = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      bitcnt_d    = 3'd0;
      tmo_d       = '0;
    end
  end

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      scandata_q   <= 8'h00;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      scandata_q   <= scandata_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Decoder acts in the scan_valid cycle; soft clear overrides any byte arriving then.
  always_comb begin
    key_on_d    = key_on_q;
    key_codes_d = key_codes_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    overflow_d  = 1'b0;
    held        = 1'b0;
    hit         = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (key_on_q[i] && key_codes_q[8*i +: 8] == scandata_q) held = 1'b1;
    end

    if (!bus.clear_n) begin
      key_on_d    = '0;
      key_codes_d = {NUM_VOICES{8'hF0}};
      brk_d       = 1'b0;
      ext_d       = 1'b0;
    end else if (scan_valid_q) begin
      if (scandata_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (scandata_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (brk_q) begin
        brk_d = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!hit && key_on_q[i] && key_codes_q[8*i +: 8] == scandata_q) begin
            key_on_d[i]          = 1'b0;
            key_codes_d[8*i +: 8] = 8'hF0;
            hit                  = 1'b1;
          end
        end
      end else if (!held && is_musical(scandata_q)) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!hit && !key_on_q[i]) begin
            key_on_d[i]          = 1'b1;
            key_codes_d[8*i +: 8] = scandata_q;
            hit                  = 1'b1;
          end
        end
        if (!hit) overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK_50 or negedge reset) begin
    if (!reset) begin
      key_on_q    <= '0;
      key_codes_q <= {NUM_VOICES{8'hF0}};
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      key_on_q    <= key_on_d;
      key_codes_q <= key_codes_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.scandata   = scandata_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.key_on     = key_on_q;
  assign bus.key_codes  = key_codes_q;

endmodule
